// File: rtl/karplus_strong_voice.sv
// karplus_strong_voice: Karplus-Strong plucked-string voice with an Avalon-MM
// register slave. The delay line is a RAM addressed by a wrapping pointer, the
// sample rate comes from a clock-enable divider, and a Galois LFSR supplies
// the pluck noise.
// Optional feature macro: DAMP_EN adds a Q0.16 damping gain register (addr 6).
module karplus_strong_voice #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [WIDTH-1:0]  syn_guitar,
    output logic              sample_valid
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LW    = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              enable_q, enable_d, irq_en_q, irq_en_d;
    logic              irq_pend_q, irq_pend_d;
    logic [LW-1:0]     len_q, len_d, act_len_q, act_len_d;
    logic [31:0]       div_q, div_d, cnt_q, cnt_d;
    logic [15:0]       seed_q, seed_d, lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  z_q, z_d, syn_q, syn_d;
    logic              valid_q, valid_d;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_q;
    logic              mem_we;
    logic [WIDTH-1:0]  mem_wdata;

    logic              wr, ctrl_wr, status_wr, div_wr, pluck_go, len_ok, at_end, tick, irq_set;
    logic [15:0]       lfsr_step;
    logic [WIDTH-1:0]  noise, avg, avg_out;
    logic signed [WIDTH:0] sum;
    logic [31:0]       rd_mux;

    assign wr        = chipselect & write;
    assign ctrl_wr   = wr && (address == 3'd0);
    assign div_wr    = wr && (address == 3'd2);
    assign status_wr = wr && (address == 3'd4);
    assign pluck_go  = ctrl_wr & writedata[1];
    assign len_ok    = (len_q >= LW'(2)) && (len_q <= LW'(DEPTH));
    assign at_end    = ({1'b0, ptr_q} == (act_len_q - LW'(1)));
    assign tick      = (div_q != 32'd0) && (cnt_q == div_q - 32'd1);
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    // Noise sample is the LFSR left-aligned in the sample word.
    generate
        if (WIDTH > 16) begin : g_noise_wide
            assign noise = {lfsr_q, {(WIDTH-16){1'b0}}};
        end else begin : g_noise_narrow
            assign noise = lfsr_q[15 -: WIDTH];
        end
    endgenerate

    // Two-tap average with one guard bit so the sum never overflows.
    assign sum = $signed({rd_q[WIDTH-1], rd_q}) + $signed({z_q[WIDTH-1], z_q});
    assign avg = WIDTH'(sum >>> 1);

`ifdef DAMP_EN
    logic [15:0] damp_q, damp_d;
    logic signed [WIDTH+16:0] prod;
    // Gain is unsigned Q0.16; the shift floors the signed product.
    assign prod    = $signed({{17{avg[WIDTH-1]}}, avg}) * $signed({{WIDTH{1'b0}}, 1'b0, damp_q});
    assign avg_out = WIDTH'(prod >>> 16);
    assign damp_d  = (wr && (address == 3'd6)) ? writedata[15:0] : damp_q;
`else
    assign avg_out = avg;
`endif

    // Register-file next state from Avalon writes; divider counter.
    always_comb begin
        enable_d   = ctrl_wr ? writedata[0] : enable_q;
        irq_en_d   = ctrl_wr ? writedata[2] : irq_en_q;
        len_d      = (wr && (address == 3'd1)) ? writedata[ADDR_W:0] : len_q;
        div_d      = div_wr ? writedata : div_q;
        seed_d     = (wr && (address == 3'd3)) ? writedata[15:0] : seed_q;
        irq_pend_d = irq_set | (irq_pend_q & ~(status_wr & writedata[1]));
        if (div_wr || (div_q == 32'd0) || tick) cnt_d = 32'd0;
        else                                    cnt_d = cnt_q + 32'd1;
    end

    // Voice FSM: pluck restart, noise fill, then tick-driven string update.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        z_d       = z_q;
        syn_d     = syn_q;
        valid_d   = 1'b0;
        act_len_d = act_len_q;
        lfsr_d    = lfsr_q;
        mem_we    = 1'b0;
        mem_wdata = noise;
        irq_set   = 1'b0;
        if (!enable_d) begin
            state_d = S_IDLE;
            syn_d   = '0;
        end else if (pluck_go && len_ok) begin
            state_d   = S_FILL;
            act_len_d = len_q;
            lfsr_d    = (seed_q == 16'd0) ? 16'hACE1 : seed_q;
            ptr_d     = '0;
            z_d       = '0;
            syn_d     = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    mem_we = 1'b1;
                    lfsr_d = lfsr_step;
                    if (at_end) begin
                        ptr_d   = '0;
                        irq_set = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        mem_we    = 1'b1;
                        mem_wdata = avg_out;
                        z_d       = rd_q;
                        ptr_d     = at_end ? '0 : ptr_q + ADDR_W'(1);
                        syn_d     = avg_out;
                        valid_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Delay-line RAM; the read is prefetched at the next pointer so the
    // current cell is ready in the tick cycle. Write and prefetch addresses
    // never coincide because the active length is at least 2.
    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q] <= mem_wdata;
        rd_q <= mem[ptr_d];
    end

    // State and control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
            len_q      <= '0;
            act_len_q  <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            seed_q     <= '0;
            lfsr_q     <= '0;
            ptr_q      <= '0;
            z_q        <= '0;
            syn_q      <= '0;
            valid_q    <= 1'b0;
`ifdef DAMP_EN
            damp_q     <= 16'hFFFF;
`endif
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            len_q      <= len_d;
            act_len_q  <= act_len_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            seed_q     <= seed_d;
            lfsr_q     <= lfsr_d;
            ptr_q      <= ptr_d;
            z_q        <= z_d;
            syn_q      <= syn_d;
            valid_q    <= valid_d;
`ifdef DAMP_EN
            damp_q     <= damp_d;
`endif
        end
    end

    // Read-back mux, driven only while a read is presented.
    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd0: rd_mux = {29'd0, irq_en_q, 1'b0, enable_q};
            3'd1: rd_mux = 32'(len_q);
            3'd2: rd_mux = div_q;
            3'd3: rd_mux = {16'd0, seed_q};
            3'd4: rd_mux = {28'd0, state_q, irq_pend_q, (state_q == S_FILL)};
            3'd5: rd_mux = 32'($signed(syn_q));
`ifdef DAMP_EN
            3'd6: rd_mux = {16'd0, damp_q};
`endif
            default: rd_mux = 32'd0;
        endcase
        readdata = (chipselect && read) ? rd_mux : 32'd0;
    end

    assign irq          = irq_pend_q & irq_en_q;
    assign syn_guitar   = syn_q;
    assign sample_valid = valid_q;
endmodule

// File: tb/tb_karplus_strong_voice.sv
// tb_karplus_strong_voice: randomized self-checking bench. The string is
// modelled as a queue rotated once per output sample.
module tb_karplus_strong_voice;
    localparam int WIDTH  = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;
    logic [WIDTH-1:0] syn_guitar;
    logic        sample_valid;

    int n_checks = 0, n_fail = 0;
    int str_q[$];
    int z_m = 0, last_exp = 0, sample_cnt = 0, ncyc = 0, last_cyc = -1, period_exp = 0;

    karplus_strong_voice #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .read(read), .writedata(writedata), .readdata(readdata),
        .irq(irq), .syn_guitar(syn_guitar), .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int half_floor(input int s);
        return (s - (((s % 2) + 2) % 2)) / 2;
    endfunction

    function automatic void model_pluck(input int len, input logic [15:0] seed);
        logic [15:0] s;
        s = (seed == 16'd0) ? 16'hACE1 : seed;
        str_q.delete();
        for (int i = 0; i < len; i++) begin
            str_q.push_back(int'($signed(s)));
            s = lfsr_adv(s);
        end
        z_m = 0;
    endfunction

    function automatic int model_sample();
        int cur, avg;
        if (str_q.size() == 0) return 32'h7fff_ffff;
        cur = str_q.pop_front();
        avg = half_floor(cur + z_m);
`ifdef DAMP_EN
        begin
            longint p;
            p = longint'(avg) * 64'sd65535;
            avg = (p >= 0) ? int'(p / 65536) : -int'((-p + 65535) / 65536);
        end
`endif
        str_q.push_back(avg);
        z_m = cur;
        return avg;
    endfunction

    // Output monitor: every sample_valid pulse is checked against the model.
    always @(negedge clk) begin
        ncyc++;
        if (reset && sample_valid) begin
            int e;
            e = model_sample();
            check_eq("sample", int'($signed(syn_guitar)), e);
            last_exp = e;
            sample_cnt++;
            if (period_exp > 0) begin
                if (last_cyc >= 0) check_eq("period", ncyc - last_cyc, period_exp);
                last_cyc = ncyc;
            end
        end
    end

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
        $display("WR addr=%0d data=0x%h", a, d);
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_run(input int budget);
        logic [31:0] st;
        int ok;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            bus_rd(3'd4, st);
            if (st[3:2] == 2'd2) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        check_eq("reach_run", ok, 1);
    endtask

    task automatic wait_samples(input int n, input int budget);
        int start;
        start = sample_cnt;
        for (int c = 0; c < budget; c++) begin
            if (sample_cnt - start >= n) break;
            @(posedge clk); #1;
        end
        check_eq("sample_count", (sample_cnt - start >= n) ? n : sample_cnt - start, n);
    endtask

    task automatic check_all_reset(input string pfx);
        logic [31:0] v;
        for (int a = 0; a < 8; a++) begin
            bus_rd(3'(a), v);
`ifdef DAMP_EN
            check_eq($sformatf("%s_reg%0d", pfx, a), int'(v), (a == 6) ? 32'hFFFF : 0);
`else
            check_eq($sformatf("%s_reg%0d", pfx, a), int'(v), 0);
`endif
        end
        check_eq({pfx, "_irq"}, int'(irq), 0);
        check_eq({pfx, "_syn"}, int'(syn_guitar), 0);
        check_eq({pfx, "_valid"}, int'(sample_valid), 0);
    endtask

    initial begin
        logic [31:0] st;
        int fill_n, start, len, dv, ie;
        logic [15:0] seed;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tick_n(1);
        check_all_reset("reset");

        // Fill length and contents for LENGTH=4, SEED=1.
        bus_wr(3'd1, 32'd4);
        bus_wr(3'd3, 32'd1);
        bus_wr(3'd2, 32'd0);
        bus_wr(3'd0, 32'd3);
        model_pluck(4, 16'd1);
        fill_n = 0;
        for (int c = 0; c < 20; c++) begin
            bus_rd(3'd4, st);
            if (!st[0]) break;
            fill_n++;
            check_eq("syn_in_fill", int'(syn_guitar), 0);
            tick_n(1);
        end
        check_eq("fill_len", fill_n, 4);
        bus_rd(3'd4, st);
        check_eq("status_after_fill", int'(st), 32'hA);
        check_eq("irq_masked", int'(irq), 0);
        bus_wr(3'd2, 32'd1);
        wait_samples(12, 40);

        // Divider 10 gives a 10-clock period; divider 0 stops output.
        bus_wr(3'd2, 32'd10);
        tick_n(1);
        last_cyc = -1; period_exp = 10;
        wait_samples(5, 80);
        period_exp = 0;
        bus_wr(3'd2, 32'd0);
        tick_n(1);
        start = sample_cnt;
        tick_n(100);
        check_eq("no_ticks_div0", sample_cnt - start, 0);
        bus_rd(3'd5, st);
        check_eq("sample_reg", int'(st), last_exp);

        // Clearing enable drops to IDLE with a zero output.
        bus_wr(3'd2, 32'd1);
        tick_n(3);
        bus_wr(3'd0, 32'd0);
        bus_rd(3'd4, st);
        check_eq("disable_state", int'(st[3:2]), 0);
        check_eq("disable_syn", int'(syn_guitar), 0);

        // Invalid plucks are ignored.
        bus_wr(3'd1, 32'd1);
        bus_wr(3'd0, 32'd3);
        bus_rd(3'd4, st);
        check_eq("len1_idle", int'(st[3:2]), 0);
        bus_wr(3'd1, DEPTH + 1);
        bus_wr(3'd0, 32'd3);
        bus_rd(3'd4, st);
        check_eq("len_over_idle", int'(st[3:2]), 0);
        bus_wr(3'd1, 32'd4);
        bus_wr(3'd0, 32'd2);
        bus_rd(3'd4, st);
        check_eq("pluck_disabled_idle", int'(st[3:2]), 0);

        // Full-depth string: pointer must wrap from DEPTH-1 to 0.
        bus_wr(3'd2, 32'd0);
        bus_wr(3'd1, DEPTH);
        bus_wr(3'd3, 32'h1234);
        bus_wr(3'd0, 32'd3);
        model_pluck(DEPTH, 16'h1234);
        wait_run(DEPTH + 50);
        bus_wr(3'd2, 32'd1);
        wait_samples(DEPTH + 6, DEPTH + 60);

        // Interrupt timing, clear, and same-clock set/clear.
        bus_wr(3'd2, 32'd0);
        bus_wr(3'd4, 32'd2);
        bus_wr(3'd1, 32'd4);
        bus_wr(3'd0, 32'd7);
        model_pluck(4, 16'h1234);
        for (int c = 0; c < 4; c++) begin
            check_eq("irq_during_fill", int'(irq), 0);
            tick_n(1);
        end
        check_eq("irq_rise", int'(irq), 1);
        bus_wr(3'd4, 32'd2);
        check_eq("irq_cleared", int'(irq), 0);
        bus_wr(3'd0, 32'd7);
        model_pluck(4, 16'h1234);
        tick_n(3);
        check_eq("irq_before_setclr", int'(irq), 0);
        bus_wr(3'd4, 32'd2);
        check_eq("irq_set_wins", int'(irq), 1);

        // Randomized plucks.
        for (int it = 0; it < 6; it++) begin
            len  = $urandom_range(2, 24);
            dv   = $urandom_range(1, 4);
            ie   = $urandom_range(0, 1);
            seed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            bus_wr(3'd2, dv);
            bus_wr(3'd1, len);
            bus_wr(3'd3, {16'd0, seed});
            bus_wr(3'd0, 32'd3 | (ie << 2));
            model_pluck(len, seed);
            last_cyc = -1; period_exp = dv;
            wait_run(len + 10);
            wait_samples(2 * len + 3, (2 * len + 3) * (dv + 1) + 20);
            period_exp = 0;
            check_eq("irq_vs_en", int'(irq), ie);
        end

        // Reset asserted mid-fill.
        bus_wr(3'd2, 32'd0);
        bus_wr(3'd1, 32'd200);
        bus_wr(3'd0, 32'd7);
        tick_n(10);
        reset = 1'b0;
        #1 check_eq("irq_in_reset", int'(irq), 0);
        tick_n(2);
        reset = 1'b1;
        tick_n(1);
        check_all_reset("midfill_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
